spatz_tcdm_bank_responder: RTL and testbench

// - Memory-side responder for one TCDM bank port of the cluster interconnect.
// - Accepts bank requests (word address, write, amo, data, strb, user) over a q_valid/q_ready handshake.
// - Returns read data exactly Latency cycles after acceptance, which is the fixed-latency contract the interconnect's shift-register response tracking relies on.
// - Holds a behavioural SRAM array and executes 32-bit atomics as read-modify-write.

---
 rtl/spatz_tcdm_bank_responder_if.sv | 27 ++
 rtl/spatz_tcdm_bank_responder.sv | 205 ++++++++++++++++++++
 tb/tb_spatz_tcdm_bank_responder.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spatz_tcdm_bank_responder_if.sv
// Request/response bundle for one TCDM bank port: requester drives q_*, bank drives q_ready and p_*.
interface spatz_tcdm_bank_responder_if #(
   parameter int unsigned AddrWidth = 10,
   parameter int unsigned DataWidth = 64,
   parameter int unsigned UserWidth = 1
);
   logic                   q_valid;
   logic                   q_ready;
   logic [AddrWidth-1:0]   q_addr;
   logic                   q_write;
   logic [3:0]             q_amo;
   logic [DataWidth-1:0]   q_data;
   logic [DataWidth/8-1:0] q_strb;
   logic [UserWidth-1:0]   q_user;
   logic [DataWidth-1:0]   p_data;
   logic                   p_valid;

   modport master (
      output q_valid, q_addr, q_write, q_amo, q_data, q_strb, q_user,
      input  q_ready, p_data, p_valid
   );

   modport slave (
      input  q_valid, q_addr, q_write, q_amo, q_data, q_strb, q_user,
      output q_ready, p_data, p_valid
   );
endinterface

// File: rtl/spatz_tcdm_bank_responder.sv
// Fixed-latency TCDM bank model: behavioural SRAM with byte-enabled writes and 32-bit lane atomics
// executed as a one-bubble read-modify-write.
module spatz_tcdm_bank_responder #(
   parameter int unsigned NumWords  = 1024,
   parameter int unsigned AddrWidth = 10,
   parameter int unsigned DataWidth = 64,
   parameter int unsigned UserWidth = 1,
   parameter int unsigned Latency   = 1
) (
   input logic                        clk_i,
   input logic                        rst_i,
   spatz_tcdm_bank_responder_if.slave bus
);
   localparam int unsigned NumLanes  = DataWidth / 32;
   localparam int unsigned StrbWidth = DataWidth / 8;
   localparam int unsigned LaneIdxW  = (NumLanes > 1) ? $clog2(NumLanes) : 1;
   localparam int unsigned IdxW      = $clog2(NumWords);

   typedef enum logic [3:0] {
      AmoNone = 4'h0,
      AmoSwap = 4'h1,
      AmoAdd  = 4'h2,
      AmoAnd  = 4'h3,
      AmoOr   = 4'h4,
      AmoXor  = 4'h5,
      AmoMax  = 4'h6,
      AmoMaxu = 4'h7,
      AmoMin  = 4'h8,
      AmoMinu = 4'h9,
      AmoLr   = 4'hA
   } amo_op_e;

   typedef enum logic {
      Idle,
      AmoWb
   } state_e;

   logic [DataWidth-1:0] mem [NumWords];

   state_e               state_q;
   logic                 q_ready_q;
   logic [IdxW-1:0]      amo_idx_q;
   amo_op_e              amo_op_q;
   logic [31:0]          amo_old_q;
   logic [31:0]          amo_operand_q;
   logic [LaneIdxW-1:0]  amo_lane_q;
   logic                 amo_we_q;

   logic                 accept;
   logic                 in_range;
   logic                 is_rmw;
   logic [IdxW-1:0]      idx;
   logic [DataWidth-1:0] rd_word;
   logic [DataWidth-1:0] wr_word;
   logic [DataWidth-1:0] rsp_word;
   logic                 lane_ok;
   logic [LaneIdxW-1:0]  lane_sel;
   logic [31:0]          old_lane;
   logic [31:0]          operand_lane;
   logic [31:0]          amo_result;
   logic [DataWidth-1:0] wb_word;

   logic [Latency-1:0]   pipe_valid_q;
   logic [DataWidth-1:0] pipe_data_q [Latency];

   logic                 unused_user;
   assign unused_user = ^bus.q_user;

   // Request decode: range check, array read, byte merge for writes and
   // selection of the single full 32-bit lane an atomic is allowed to touch.
   always_comb begin
      accept   = bus.q_valid & q_ready_q;
      in_range = 32'(bus.q_addr) < NumWords;
      is_rmw   = !bus.q_write && (bus.q_amo >= AmoSwap) && (bus.q_amo <= AmoMinu);
      idx      = bus.q_addr[IdxW-1:0];
      rd_word  = in_range ? mem[idx] : '0;

      wr_word = rd_word;
      for (int b = 0; b < StrbWidth; b++) begin
         if (bus.q_strb[b]) begin
            wr_word[8*b +: 8] = bus.q_data[8*b +: 8];
         end
      end

      lane_ok  = 1'b0;
      lane_sel = '0;
      for (int k = 0; k < NumLanes; k++) begin
         if (bus.q_strb == (StrbWidth'(4'hF) << (4*k))) begin
            lane_ok  = 1'b1;
            lane_sel = LaneIdxW'(k);
         end
      end

      old_lane     = '0;
      operand_lane = '0;
      for (int k = 0; k < NumLanes; k++) begin
         if (LaneIdxW'(k) == lane_sel) begin
            old_lane     = rd_word[32*k +: 32];
            operand_lane = bus.q_data[32*k +: 32];
         end
      end

      // SC and undefined codes answer 1 without touching memory; LR behaves as a read.
      if (bus.q_write || !in_range) begin
         rsp_word = '0;
      end else if (bus.q_amo == AmoNone || bus.q_amo == AmoLr || is_rmw) begin
         rsp_word = rd_word;
      end else begin
         rsp_word = DataWidth'(1);
      end
   end

   // Atomic operation on the latched lane, merged back into the untouched word.
   always_comb begin
      case (amo_op_q)
         AmoSwap: amo_result = amo_operand_q;
         AmoAdd:  amo_result = amo_old_q + amo_operand_q;
         AmoAnd:  amo_result = amo_old_q & amo_operand_q;
         AmoOr:   amo_result = amo_old_q | amo_operand_q;
         AmoXor:  amo_result = amo_old_q ^ amo_operand_q;
         AmoMax:  amo_result = ($signed(amo_old_q) > $signed(amo_operand_q)) ? amo_old_q : amo_operand_q;
         AmoMaxu: amo_result = (amo_old_q > amo_operand_q) ? amo_old_q : amo_operand_q;
         AmoMin:  amo_result = ($signed(amo_old_q) < $signed(amo_operand_q)) ? amo_old_q : amo_operand_q;
         AmoMinu: amo_result = (amo_old_q < amo_operand_q) ? amo_old_q : amo_operand_q;
         default: amo_result = amo_old_q;
      endcase

      wb_word = mem[amo_idx_q];
      for (int k = 0; k < NumLanes; k++) begin
         if (LaneIdxW'(k) == amo_lane_q) begin
            wb_word[32*k +: 32] = amo_result;
         end
      end
   end

   // Control FSM: an accepted atomic parks the port for one write-back cycle.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q       <= Idle;
         q_ready_q     <= 1'b1;
         amo_idx_q     <= '0;
         amo_op_q      <= AmoNone;
         amo_old_q     <= '0;
         amo_operand_q <= '0;
         amo_lane_q    <= '0;
         amo_we_q      <= 1'b0;
      end else begin
         case (state_q)
            Idle: begin
               if (accept && is_rmw) begin
                  state_q       <= AmoWb;
                  q_ready_q     <= 1'b0;
                  amo_idx_q     <= idx;
                  amo_op_q      <= amo_op_e'(bus.q_amo);
                  amo_old_q     <= old_lane;
                  amo_operand_q <= operand_lane;
                  amo_lane_q    <= lane_sel;
                  amo_we_q      <= in_range && lane_ok;
               end
            end
            AmoWb: begin
               state_q   <= Idle;
               q_ready_q <= 1'b1;
               amo_we_q  <= 1'b0;
            end
            default: begin
               state_q   <= Idle;
               q_ready_q <= 1'b1;
            end
         endcase
      end
   end

   // Array update; reset suppresses both paths so an interrupted atomic leaves the word intact.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         if (accept && bus.q_write && in_range) begin
            mem[idx] <= wr_word;
         end else if (state_q == AmoWb && amo_we_q) begin
            mem[amo_idx_q] <= wb_word;
         end
      end
   end

   // Response delay line; idle slots carry zero data so p_data is quiet between pulses.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pipe_valid_q <= '0;
         for (int i = 0; i < Latency; i++) begin
            pipe_data_q[i] <= '0;
         end
      end else begin
         pipe_valid_q[0] <= accept;
         pipe_data_q[0]  <= accept ? rsp_word : '0;
         for (int i = 1; i < Latency; i++) begin
            pipe_valid_q[i] <= pipe_valid_q[i-1];
            pipe_data_q[i]  <= pipe_data_q[i-1];
         end
      end
   end

   assign bus.q_ready = q_ready_q;
   assign bus.p_valid = pipe_valid_q[Latency-1];
   assign bus.p_data  = pipe_data_q[Latency-1];
endmodule

// File: tb/tb_spatz_tcdm_bank_responder.sv
// Drives a Latency=1 and a Latency=3 bank with identical traffic and scores both against a word-level memory model.
module tb_spatz_tcdm_bank_responder;
   localparam int NW = 16;
   localparam int AW = 5;
   localparam int DW = 64;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          q_valid = 1'b0;
   logic [AW-1:0] q_addr = '0;
   logic          q_write = 1'b0;
   logic [3:0]    q_amo = '0;
   logic [DW-1:0] q_data = '0;
   logic [7:0]    q_strb = '0;
   logic [0:0]    q_user = '0;

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   spatz_tcdm_bank_responder_if #(.AddrWidth(AW), .DataWidth(DW), .UserWidth(1)) bus1 ();
   spatz_tcdm_bank_responder_if #(.AddrWidth(AW), .DataWidth(DW), .UserWidth(1)) bus3 ();

   assign bus1.q_valid = q_valid;
   assign bus1.q_addr  = q_addr;
   assign bus1.q_write = q_write;
   assign bus1.q_amo   = q_amo;
   assign bus1.q_data  = q_data;
   assign bus1.q_strb  = q_strb;
   assign bus1.q_user  = q_user;
   assign bus3.q_valid = q_valid;
   assign bus3.q_addr  = q_addr;
   assign bus3.q_write = q_write;
   assign bus3.q_amo   = q_amo;
   assign bus3.q_data  = q_data;
   assign bus3.q_strb  = q_strb;
   assign bus3.q_user  = q_user;

   spatz_tcdm_bank_responder #(
      .NumWords(NW), .AddrWidth(AW), .DataWidth(DW), .UserWidth(1), .Latency(1)
   ) dut1 (
      .clk_i(clk),
      .rst_i(rst),
      .bus  (bus1.slave)
   );

   spatz_tcdm_bank_responder #(
      .NumWords(NW), .AddrWidth(AW), .DataWidth(DW), .UserWidth(1), .Latency(3)
   ) dut3 (
      .clk_i(clk),
      .rst_i(rst),
      .bus  (bus3.slave)
   );

   typedef struct {
      logic [63:0] data;
      int          cyc;
   } exp_t;

   exp_t        sb [2][$];
   logic [63:0] mm [NW];
   int          total = 0;
   int          bad = 0;
   bit          bubble_pending = 1'b0;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   // Reference memory: applies the access to mm and returns the response word.
   function automatic logic [63:0] model_access(input logic [AW-1:0] a, input bit w,
                                                input logic [3:0] amo, input logic [63:0] d,
                                                input logic [7:0] s, output bit bub);
      logic [63:0] old;
      logic [31:0] o;
      logic [31:0] x;
      logic [31:0] r;
      int          lane;
      bit          inr;
      bub = 1'b0;
      inr = (a < NW);
      if (w) begin
         if (inr) begin
            for (int b = 0; b < 8; b++) begin
               if (s[b]) mm[a[3:0]][8*b +: 8] = d[8*b +: 8];
            end
         end
         return 64'd0;
      end
      if (amo == 4'h0 || amo == 4'hA) return inr ? mm[a[3:0]] : 64'd0;
      if (amo <= 4'h9) begin
         bub = 1'b1;
         if (!inr) return 64'd0;
         old  = mm[a[3:0]];
         lane = -1;
         if (s == 8'h0F) lane = 0;
         else if (s == 8'hF0) lane = 1;
         if (lane >= 0) begin
            o = old[32*lane +: 32];
            x = d[32*lane +: 32];
            case (amo)
               4'h1: r = x;
               4'h2: r = o + x;
               4'h3: r = o & x;
               4'h4: r = o | x;
               4'h5: r = o ^ x;
               4'h6: r = ($signed(o) > $signed(x)) ? o : x;
               4'h7: r = (o > x) ? o : x;
               4'h8: r = ($signed(o) < $signed(x)) ? o : x;
               default: r = (o < x) ? o : x;
            endcase
            mm[a[3:0]][32*lane +: 32] = r;
         end
         return old;
      end
      return inr ? 64'd1 : 64'd0;
   endfunction

   task automatic mon(input int p, input logic v, input logic [63:0] d);
      exp_t  e;
      bit    exp_v;
      string tag;
      tag = (p == 0) ? "L1" : "L3";
      while (sb[p].size() > 0 && sb[p][0].cyc < cyc) void'(sb[p].pop_front());
      exp_v = (sb[p].size() > 0) && (sb[p][0].cyc == cyc);
      chk({tag, " p_valid"}, {63'b0, v}, {63'b0, exp_v});
      if (exp_v) begin
         e = sb[p].pop_front();
         chk({tag, " p_data"}, d, e.data);
      end else begin
         chk({tag, " idle p_data"}, d, 64'd0);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         mon(0, bus1.p_valid, bus1.p_data);
         mon(1, bus3.p_valid, bus3.p_data);
      end
   end

   task automatic check_ready();
      bit exp_r;
      exp_r = !bubble_pending;
      bubble_pending = 1'b0;
      chk("L1 q_ready", {63'b0, bus1.q_ready}, {63'b0, exp_r});
      chk("L3 q_ready", {63'b0, bus3.q_ready}, {63'b0, exp_r});
   endtask

   task automatic applyStimulus(input logic [AW-1:0] a, input bit w, input logic [3:0] amo,
                                input logic [63:0] d, input logic [7:0] s);
      logic [63:0] resp;
      bit          bub;
      q_valid = 1'b1;
      q_addr  = a;
      q_write = w;
      q_amo   = amo;
      q_data  = d;
      q_strb  = s;
      q_user  = 1'($urandom);
      @(negedge clk);
      if (bubble_pending) begin
         check_ready();
         @(negedge clk);
      end
      check_ready();
      resp = model_access(a, w, amo, d, s, bub);
      sb[0].push_back('{resp, cyc + 1});
      sb[1].push_back('{resp, cyc + 3});
      bubble_pending = bub;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_cycles(input int n);
      q_valid = 1'b0;
      repeat (n) begin
         @(negedge clk);
         check_ready();
         @(posedge clk);
         #1;
      end
   endtask

   task automatic checkOutput();
      idle_cycles(6);
      chk("L1 scoreboard drained", 64'(sb[0].size()), 64'd0);
      chk("L3 scoreboard drained", 64'(sb[1].size()), 64'd0);
   endtask

   initial begin
      logic [63:0] saved;
      logic [AW-1:0] ra;
      logic [3:0]    ramo;
      logic [7:0]    rs;
      int            kind;

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("L1 reset p_valid", {63'b0, bus1.p_valid}, 64'd0);
      chk("L3 reset p_valid", {63'b0, bus3.p_valid}, 64'd0);
      chk("L1 reset p_data", bus1.p_data, 64'd0);
      chk("L3 reset p_data", bus3.p_data, 64'd0);
      check_ready();
      @(posedge clk);
      #1;

      for (int a = 0; a < NW; a++) begin
         applyStimulus(AW'(a), 1'b1, 4'h0, {$urandom, $urandom}, 8'hFF);
      end

      applyStimulus(5'd5, 1'b1, 4'h0, 64'h1122_3344_5566_7788, 8'hFF);
      applyStimulus(5'd5, 1'b0, 4'h0, 64'h0, 8'hFF);

      applyStimulus(5'd3, 1'b1, 4'h0, 64'h0, 8'hFF);
      applyStimulus(5'd3, 1'b1, 4'h0, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F);
      applyStimulus(5'd3, 1'b0, 4'h0, 64'h0, 8'hFF);

      applyStimulus(5'd7, 1'b1, 4'h0, 64'h0000_0001_FFFF_FFFF, 8'hFF);
      applyStimulus(5'd7, 1'b0, 4'h2, 64'h0000_0000_0000_0001, 8'h0F);
      applyStimulus(5'd7, 1'b0, 4'h0, 64'h0, 8'hFF);

      applyStimulus(5'd8, 1'b1, 4'h0, 64'h0000_0000_FFFF_FFFF, 8'hFF);
      applyStimulus(5'd8, 1'b0, 4'h6, 64'h0000_0000_0000_0002, 8'h0F);
      applyStimulus(5'd8, 1'b0, 4'h0, 64'h0, 8'hFF);
      applyStimulus(5'd8, 1'b1, 4'h0, 64'h0000_0000_FFFF_FFFF, 8'hFF);
      applyStimulus(5'd8, 1'b0, 4'h7, 64'h0000_0000_0000_0002, 8'h0F);
      applyStimulus(5'd8, 1'b0, 4'h0, 64'h0, 8'hFF);

      for (int a = 0; a < 4; a++) begin
         applyStimulus(AW'(a), 1'b0, 4'h0, 64'h0, 8'hFF);
      end
      idle_cycles(4);

      saved = mm[2];
      applyStimulus(5'd2, 1'b0, 4'h2, 64'h0000_0000_1234_5678, 8'h0F);
      rst = 1'b1;
      q_valid = 1'b0;
      mm[2] = saved;
      sb[0].delete();
      sb[1].delete();
      bubble_pending = 1'b0;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("L1 post-reset p_valid", {63'b0, bus1.p_valid}, 64'd0);
      chk("L3 post-reset p_valid", {63'b0, bus3.p_valid}, 64'd0);
      check_ready();
      @(posedge clk);
      #1;
      applyStimulus(5'd2, 1'b0, 4'h0, 64'h0, 8'hFF);

      for (int n = 0; n < 300; n++) begin
         ra   = AW'($urandom_range(0, 19));
         kind = $urandom_range(0, 9);
         case ($urandom_range(0, 3))
            0:       rs = 8'h0F;
            1:       rs = 8'hF0;
            2:       rs = 8'hFF;
            default: rs = 8'($urandom);
         endcase
         if (kind < 4) begin
            applyStimulus(ra, 1'b0, 4'h0, {$urandom, $urandom}, rs);
         end else if (kind < 7) begin
            applyStimulus(ra, 1'b1, 4'($urandom), {$urandom, $urandom}, rs);
         end else begin
            ramo = 4'($urandom_range(1, 15));
            if (ramo >= 4'hB) ra = {1'b0, ra[3:0]};
            applyStimulus(ra, 1'b0, ramo, {$urandom, $urandom}, rs);
         end
         if ($urandom_range(0, 3) == 0) idle_cycles(1);
      end

      checkOutput();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
